// File: rtl/cp0_exception_unit.sv
// CP0 register file with interrupt/exception control, sitting beside the M stage.
// Optional Count/Compare timer on HWInt[5] is enabled by defining CP0_TIMER_EN.
module cp0_exception_unit #(
    parameter logic [31:0] PRID    = 32'h0000_4B43,
    parameter logic [31:0] SR_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic        ExcValid,
    input  logic [4:0]  ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic [5:0]  hwint_eff;
    logic        int_pend;
    logic        mtc0_wr;
    logic [31:0] epc_target;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tpend_q, tpend_d;

    assign hwint_eff = {HWInt[5] | tpend_q, HWInt[4:0]};

    // Compare write clears the sticky pending flag even if Count matches this cycle.
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        tpend_d   = tpend_q | (count_q == compare_q);
        if (mtc0_wr && A2 == REG_COUNT) begin
            count_d = DIn;
        end
        if (mtc0_wr && A2 == REG_COMPARE) begin
            compare_d = DIn;
            tpend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            compare_q <= '0;
            tpend_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tpend_q   <= tpend_d;
        end
    end
`else
    assign hwint_eff = HWInt;
`endif

    assign int_pend   = (|(hwint_eff & im_q)) & ie_q & ~exl_q;
    assign IntReq     = int_pend | ExcValid;
    // An instruction squashed by IntReq must not retire its mtc0; eret outranks mtc0.
    assign mtc0_wr    = We & ~IntReq & ~EXLClr;
    assign epc_target = (BD ? (PC - 32'd4) : PC) & ~32'h3;

    assign sr_word    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause_word = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};
    assign EPC        = epc_q;

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ip_d      = hwint_eff;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (IntReq) begin
            exl_d     = 1'b1;
            exccode_d = int_pend ? 5'd0 : ExcCode;
            if (!exl_q) begin
                bd_d  = BD;
                epc_d = epc_target;
            end
        end else begin
            if (EXLClr) begin
                exl_d = 1'b0;
            end
            if (mtc0_wr) begin
                case (A2)
                    REG_SR: begin
                        im_d  = DIn[15:10];
                        exl_d = DIn[1];
                        ie_d  = DIn[0];
                    end
                    REG_EPC: epc_d = DIn;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            im_q      <= SR_INIT[15:10];
            exl_q     <= SR_INIT[1];
            ie_q      <= SR_INIT[0];
            bd_q      <= 1'b0;
            ip_q      <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        DOut = '0;
        case (A1)
`ifdef CP0_TIMER_EN
            REG_COUNT:   DOut = count_q;
            REG_COMPARE: DOut = compare_q;
`endif
            REG_SR:      DOut = sr_word;
            REG_CAUSE:   DOut = cause_word;
            REG_EPC:     DOut = epc_q;
            REG_PRID:    DOut = PRID;
            default:     DOut = '0;
        endcase
    end

endmodule
